txmem_loader: RTL and testbench
===============================

Name: txmem_loader

Overview:
SysClk-domain write engine for port A of the SPI transmit memory (the 1024 x 32 side that the SPI interface reads byte-wise on SPI_CLK).
- After reset it pattern-fills the whole memory.
- It then accepts host-initiated block loads: a base address and length, followed by a valid/ready word stream.
- Each accepted word is written to sequential, wrapping addresses.
- It replaces ad-hoc init-write logic in the wrapper and sits directly upstream of the transmit memory.

Parameters:
ADDR_W, 10, memory port A address width
DATA_W, 32, memory port A data width
FILL_PATTERN, 32'h5A6C_C6A5, word written to every address during fill

Ports:
SysClk  in  1  system clock; all logic on rising edge
Reset_n  in  1  asynchronous, active-low reset
fill_req  in  1  pulse; request full-memory pattern fill
load_start  in  1  pulse; begin block load using load_base/load_len
load_base  in  ADDR_W  first write address of block load
load_len  in  ADDR_W+1  words in block load, valid 1..1024
s_valid  in  1  host word valid
s_data  in  DATA_W  host word
s_ready  out  1  loader accepts word this cycle
mem_we  out  1  port A write enable (wea)
mem_addr  out  ADDR_W  port A address (addra)
mem_din  out  DATA_W  port A write data (dina)
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse at end of fill or load
len_err  out  1  one-cycle pulse, load_start with load_len==0 or >1024
words_written  out  ADDR_W+1  words written by current/last operation

Behaviour:
- States: FILL, IDLE, LOAD, FINISH. Reset state is FILL.
- Reset values: mem_we=0, mem_addr=0, mem_din=0, s_ready=0, done=0, len_err=0, words_written=0, busy=1, internal counters 0.
- Reset asserted mid-operation: all registers clear immediately (async). The in-flight write is abandoned; no partial mem_we after reset.
- On release, FILL restarts from address 0.
- mem_we, mem_addr and mem_din are registered. A write appears on these ports the cycle after its originating event; port A latches it on the following edge.
- FILL:
  - One write per cycle: mem_we=1, mem_din=FILL_PATTERN, mem_addr=0,1,...,1023.
  - Exactly 1024 consecutive mem_we cycles; words_written increments per write and ends at 1024.
  - After the write to 10'h3FF issues, go to FINISH.
  - s_ready=0 throughout; load_start and fill_req are ignored.
- IDLE:
  - busy=0, s_ready=0, mem_we=0.
  - fill_req=1: clear words_written, go to FILL. fill_req takes priority over a simultaneous load_start.
  - load_start=1 with 1<=load_len<=1024: latch base and length, clear words_written, go to LOAD.
  - load_start=1 with load_len==0 or >1024: len_err pulses for 1 cycle, stay in IDLE.
- LOAD:
  - s_ready=1 combinationally while remaining count > 0.
  - Each cycle with s_valid&&s_ready: next cycle mem_we=1, mem_addr=(base+words_written) mod 1024, mem_din=s_data; words_written increments.
  - Address wraps 10'h3FF -> 10'h000.
  - s_valid gaps produce mem_we=0 cycles; no timeout.
  - When the last word is accepted, s_ready drops the same cycle and the state goes to FINISH.
  - fill_req and load_start are ignored.
- FINISH: one cycle. done=1, busy=1, the final mem_we of the operation is visible this cycle, then go to IDLE.
- words_written holds its value in IDLE until the next operation starts.

Test Plan:
- Reset release: Reset_n low then high -> mem_we high for exactly 1024 consecutive cycles, addr 0..1023, din 32'h5A6CC6A5. done pulses once; busy falls the cycle after done; words_written=1024.
- Back-to-back load: base=10'h010, len=4, s_valid held high with data 1,2,3,4 -> writes at 0x010..0x013 with 1..4 in 4 consecutive cycles. s_ready is high for exactly 4 cycles; done pulses once; words_written=4.
- Wrap and stalls: base=10'h3FE, len=3, s_valid toggled 1,0,1,0,1 -> writes to 0x3FE, 0x3FF, 0x000, with mem_we low on stall cycles.
- Length errors: load_start with len=0, then with len=1025 -> len_err pulses each time. State stays IDLE, no mem_we, s_ready stays 0.
- Priority and ignore: fill_req and load_start in the same IDLE cycle -> FILL runs (1024 pattern writes). A load_start issued during FILL is ignored.
- Mid-load reset: during a len=8 load, Reset_n low after 3 words -> outputs clear immediately. On release a full 1024-word FILL runs, and no stale load writes appear.

Source files
------------

// File: rtl/txmem_loader.sv
// Port-A write engine for the SPI transmit memory.
// Pattern-fills the whole memory after reset or on request, then streams host
// block loads (base/length + valid/ready words) into sequential wrapping addresses.
module txmem_loader #(
  parameter int unsigned       ADDR_W       = 10,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [DATA_W-1:0] FILL_PATTERN = 32'h5A6C_C6A5
) (
  input  logic              SysClk,
  input  logic              Reset_n,
  input  logic              fill_req,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [ADDR_W:0]   words_written
);

  localparam int unsigned     Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MaxLen   = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0] LastFill = (ADDR_W + 1)'(Depth - 1);
  localparam logic [ADDR_W:0] OneWord  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StFill, StIdle, StLoad, StFinish} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     remain_q;
  logic [ADDR_W:0]     words_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_din_q;
  logic                done_q;
  logic                len_err_q;

  logic                accept;
  logic                len_ok;

  // Handshake and length qualification; s_ready depends only on state, not on s_valid.
  always_comb begin
    s_ready = (state_q == StLoad) && (remain_q != '0);
    accept  = s_ready && s_valid;
    len_ok  = (load_len != '0) && (load_len <= MaxLen);
  end

  // Control FSM with registered memory-port and status outputs.
  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StFill;
      base_q     <= '0;
      remain_q   <= '0;
      words_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      // Pulses default low; address/data simply hold between writes.
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      case (state_q)
        StFill: begin
          // words_q doubles as the fill address counter.
          mem_we_q   <= 1'b1;
          mem_addr_q <= words_q[ADDR_W-1:0];
          mem_din_q  <= FILL_PATTERN;
          words_q    <= words_q + OneWord;
          if (words_q == LastFill) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
          end
        end
        StIdle: begin
          if (fill_req) begin
            words_q <= '0;
            state_q <= StFill;
          end else if (load_start) begin
            if (len_ok) begin
              base_q   <= load_base;
              remain_q <= load_len;
              words_q  <= '0;
              state_q  <= StLoad;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            mem_we_q   <= 1'b1;
            // Natural ADDR_W-bit overflow gives the wrap from the top address to 0.
            mem_addr_q <= base_q + words_q[ADDR_W-1:0];
            mem_din_q  <= s_data;
            words_q    <= words_q + OneWord;
            remain_q   <= remain_q - OneWord;
            if (remain_q == OneWord) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    mem_we        = mem_we_q;
    mem_addr      = mem_addr_q;
    mem_din       = mem_din_q;
    done          = done_q;
    len_err       = len_err_q;
    words_written = words_q;
    busy          = (state_q != StIdle);
  end

endmodule

// File: tb/tb_txmem_loader.sv
// Self-checking bench for txmem_loader: randomized block loads against a
// queue/array reference model of the expected port-A write stream.
module tb_txmem_loader;

  localparam int          AW    = 10;
  localparam int          DW    = 32;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] PAT   = 32'h5A6C_C6A5;

  logic          SysClk = 1'b0;
  logic          Reset_n = 1'b1;
  logic          fill_req = 1'b0;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   load_len = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          busy;
  logic          done;
  logic          len_err;
  logic [AW:0]   words_written;

  txmem_loader dut (
    .SysClk        (SysClk),
    .Reset_n       (Reset_n),
    .fill_req      (fill_req),
    .load_start    (load_start),
    .load_base     (load_base),
    .load_len      (load_len),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .busy          (busy),
    .done          (done),
    .len_err       (len_err),
    .words_written (words_written)
  );

  always #5 SysClk = ~SysClk;

  int cyc = 0;
  always @(posedge SysClk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Observed and expected write streams: {cycle, addr, data}.
  logic [63:0] wr_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] obs_mem[DEPTH];
  logic [31:0] exp_mem[DEPTH];
  int          done_cnt = 0;
  int          lerr_cnt = 0;
  int          ready_cnt = 0;
  logic        done_prev = 1'b0;

  // Monitor: sample away from the rising edge.
  always @(negedge SysClk) begin
    if (Reset_n) begin
      if (mem_we === 1'b1) begin
        wr_q.push_back({22'(cyc), mem_addr, mem_din});
        obs_mem[mem_addr] = mem_din;
      end
      if (done === 1'b1) begin
        done_cnt++;
        check_eq("busy_with_done", 64'(busy), 64'(1));
      end
      if (len_err === 1'b1) lerr_cnt++;
      if (s_ready === 1'b1) ready_cnt++;
      if (done_prev) check_eq("busy_after_done", 64'(busy), 64'(0));
      done_prev = (done === 1'b1);
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge SysClk);
    #1;
  endtask

  task automatic clear_obs();
    wr_q.delete();
    exp_q.delete();
    done_cnt  = 0;
    lerr_cnt  = 0;
    ready_cnt = 0;
  endtask

  task automatic expect_fill(input int first);
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back({22'(first + i), 10'(i), PAT});
      exp_mem[i] = PAT;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 4000) begin
      @(negedge SysClk);
      n++;
    end
    check_eq("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic compare_writes(input string tag);
    check_eq({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) check_eq(tag, wr_q[i], exp_q[i]);
  endtask

  task automatic finish_op(input string tag, input int len);
    wait_idle();
    compare_writes(tag);
    check_eq({tag, "_done"}, 64'(done_cnt), 64'(1));
    check_eq({tag, "_ww"}, 64'(words_written), 64'(len));
  endtask

  // Assert reset, check cleared outputs, release and check the full pattern fill.
  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    check_eq("rst_we", 64'(mem_we), 64'(0));
    check_eq("rst_addr", 64'(mem_addr), 64'(0));
    check_eq("rst_din", 64'(mem_din), 64'(0));
    check_eq("rst_ready", 64'(s_ready), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_lerr", 64'(len_err), 64'(0));
    check_eq("rst_ww", 64'(words_written), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(1));
    tick();
    tick();
    clear_obs();
    Reset_n = 1'b1;
    expect_fill(cyc + 1);
    tick();
    finish_op("fill_rst", DEPTH);
  endtask

  // mode 0: s_valid always high; 1: alternating 1,0,1,...; 2: random.
  task automatic run_load(input string tag, input int base, input int len, input int mode);
    int k = 0;
    int loopc = 0;
    logic v;
    logic [31:0] d;
    clear_obs();
    load_base  = 10'(base);
    load_len   = 11'(len);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    while (k < len && loopc < 8000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (loopc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d       = $urandom;
      s_valid = v;
      s_data  = d;
      if (v) begin
        exp_q.push_back({22'(cyc + 1), 10'(base + k), d});
        exp_mem[(base + k) % DEPTH] = d;
        k++;
      end
      loopc++;
      tick();
    end
    s_valid = 1'b0;
    finish_op(tag, len);
    check_eq({tag, "_ready"}, 64'(ready_cnt), 64'(loopc));
  endtask

  task automatic bad_len(input int len);
    clear_obs();
    load_base  = 10'($urandom);
    load_len   = 11'(len);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tick();
    tick();
    check_eq("lerr_cnt", 64'(lerr_cnt), 64'(1));
    check_eq("lerr_nwr", 64'(wr_q.size()), 64'(0));
    check_eq("lerr_ready", 64'(ready_cnt), 64'(0));
    check_eq("lerr_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int base;
    #2;
    do_reset();

    run_load("b2b", 'h010, 4, 0);
    run_load("wrap", 'h3FE, 3, 1);

    bad_len(0);
    bad_len(1025);
    bad_len(int'($urandom_range(1026, 2047)));

    // fill_req wins over a simultaneous load_start; a load_start during FILL is ignored.
    clear_obs();
    fill_req   = 1'b1;
    load_start = 1'b1;
    load_base  = 10'h020;
    load_len   = 11'd5;
    expect_fill(cyc + 2);
    tick();
    fill_req   = 1'b0;
    load_start = 1'b0;
    repeat (10) tick();
    load_start = 1'b1;
    s_valid    = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (3) tick();
    s_valid = 1'b0;
    finish_op("prio_fill", DEPTH);
    check_eq("prio_ready", 64'(ready_cnt), 64'(0));

    for (int t = 0; t < 6; t++) begin
      run_load("rand", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2);
    end
    run_load("full", int'($urandom_range(0, DEPTH - 1)), DEPTH, 2);

    for (int i = 0; i < DEPTH; i++) check_eq("mem", 64'(obs_mem[i]), 64'(exp_mem[i]));

    // Reset three words into an 8-word load: fill must run cleanly afterwards.
    base = int'($urandom_range(0, DEPTH - 1));
    clear_obs();
    load_base  = 10'(base);
    load_len   = 11'd8;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    s_valid    = 1'b1;
    repeat (3) begin
      s_data = $urandom;
      tick();
    end
    s_valid = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
